instr_fetch_unit: RTL

Instruction fetch stage of each RISC-V core. It owns the program counter and issues single-outstanding word requests to the instruction cache/memory port. It delivers each fetched instruction with its PC through a registered IF/ID output to the decode controller, and honours decode stall and execute-stage branch/jump redirects.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_skid_buffer.sv | 34 +++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry IF/ID payload holding register, used when decode stalls on a full output.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  logic  drain,
  input  logic  flush,
  input  ifid_t din,
  output logic  valid,
  output ifid_t dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word requests and
// presents each fetched instruction through a registered IF/ID output with a skid entry.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  fetch_state_e state;
  logic [31:0]  pc_p0;
  logic [31:0]  req_pc_p0;
  ifid_t        out_p1;
  logic         vld_p1;
  logic         skid_vld;
  ifid_t        skid_dout;
  ifid_t        rsp_p0;
  logic         accept;
  logic         rsp_ok;
  logic         load_out;
  logic         load_skid;
  logic         drain_skid;

  assign imem_req  = (state == REQ) && !skid_vld;
  assign imem_addr = pc_p0;
  assign accept    = imem_req && imem_ready;

  // Responses are only taken in WAIT; a redirect in the same cycle discards them.
  assign rsp_ok     = (state == WAIT) && imem_rvalid && !redirect;
  assign load_out   = rsp_ok && (!vld_p1 || !stall);
  assign load_skid  = rsp_ok && vld_p1 && stall;
  assign drain_skid = skid_vld && !stall && !redirect;
  assign rsp_p0     = '{instr: imem_rdata, pc: req_pc_p0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc_p0 <= RESET_PC;
    end else if (redirect) begin
      pc_p0 <= word_align(redirect_pc);
      case (state)
        IDLE:    state <= REQ;
        REQ:     state <= accept ? DROP : REQ;
        WAIT:    state <= imem_rvalid ? REQ : DROP;
        DROP:    state <= imem_rvalid ? REQ : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (accept) begin
            state <= WAIT;
            pc_p0 <= pc_p0 + 32'd4;
          end
        end
        WAIT:    if (imem_rvalid) state <= REQ;
        DROP:    if (imem_rvalid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_pc_p0 <= pc_p0;
    end
  end

  // ---- IF/ID output register (stage 1) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      out_p1 <= '{instr: NOP_INSTR, pc: RESET_PC};
    end else if (redirect) begin
      vld_p1       <= 1'b0;
      out_p1.instr <= NOP_INSTR;
    end else if (load_out) begin
      vld_p1 <= 1'b1;
      out_p1 <= rsp_p0;
    end else if (drain_skid) begin
      vld_p1 <= 1'b1;
      out_p1 <= skid_dout;
    end else if (vld_p1 && !stall) begin
      vld_p1       <= 1'b0;
      out_p1.instr <= NOP_INSTR;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_skid),
    .drain   (drain_skid),
    .flush   (redirect),
    .din     (rsp_p0),
    .valid   (skid_vld),
    .dout    (skid_dout)
  );

  assign instr       = out_p1.instr;
  assign instr_pc    = out_p1.pc;
  assign instr_valid = vld_p1;

endmodule
